uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial-to-parallel UART receiver, 8N1, LSB first, line idles high. It is the receive end of the UART link driven by the team's transmitter/driver pair. It samples the asynchronous RxD pin, validates the start and stop bits, and presents each byte to a downstream consumer. The consumer clears the sticky ready flag with a one-cycle acknowledge.

Parameters:
CLKS_PER_BIT, 434, Clock cycles per bit period (50 MHz / 115200); must be >= 4.
HALF_BIT, CLKS_PER_BIT/2, Cycles from the detected start edge to the start-bit mid-sample.

Ports:
Clock  input  1  System clock; all logic is on the posedge.
Reset  input  1  Synchronous, active-high reset.
RxD  input  1  Asynchronous serial line, idle high.
RxAck  input  1  One-cycle pulse from the consumer; clears RxReady, Overrun and FrameError.
RxData  output  8  Last correctly framed byte; bit 0 is the first data bit received.
RxReady  output  1  Sticky; high while RxData holds an unacknowledged byte.
FrameError  output  1  Sticky; stop bit sampled low.
Overrun  output  1  Sticky; a new byte completed while RxReady was still high.
Busy  output  1  High in every state except RX_IDLE.

Behaviour:
- Reset: the next posedge forces RxData=0, RxReady=0, FrameError=0, Overrun=0, Busy=0, state=RX_IDLE, bit counter=0, baud counter=0. Synchronizer flops load 1. Reset mid-frame abandons the frame without updating any output.
- Input sync: 2-flop synchronizer, both stages preset 1. All logic uses only the second stage (rxs).
- Baud counter: width $clog2(CLKS_PER_BIT). It clears on every state change and otherwise increments.
- RX_IDLE: if rxs==0, go to RX_START with the counter at 0.
- RX_START: when the counter reaches HALF_BIT-1, sample rxs.
  - 0: go to RX_DATA, bit index=0.
  - 1: glitch; return to RX_IDLE. No flags change.
- RX_DATA: when the counter reaches CLKS_PER_BIT-1, shift rxs into the MSB of an 8-bit shift register (shift right) and increment the bit index. After the 8th sample (index 7), go to RX_STOP.
- RX_STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs.
  - 1: RxData<=shift register, RxReady<=1, Overrun<=Overrun|(RxReady&~RxAck); go to RX_IDLE.
  - 0: FrameError<=1; RxData and RxReady unchanged; go to RX_BREAK.
- RX_BREAK: wait until rxs==1, then go to RX_IDLE. This prevents a held-low line (break) from being taken as a new start.
- Outputs are registered. RxReady rises on the posedge following the stop-sample cycle. The stop sample falls HALF_BIT + 9*CLKS_PER_BIT cycles after RX_IDLE first sees rxs==0.
- RxAck with no byte completing: RxReady, Overrun and FrameError all go to 0 on that posedge.
- RxAck in the same cycle a byte completes: the completion wins. RxReady stays 1, RxData updates, Overrun is not set. Overrun and FrameError are cleared.
- RxAck while RxReady==0: flags clear; no other effect.
- Back-to-back frames: a start edge in the cycle after leaving RX_STOP must be caught, so there is no dead time beyond one cycle in RX_IDLE.
- On overrun, the newer byte overwrites RxData.
- Busy = (state != RX_IDLE).

Test Plan:
- CLKS_PER_BIT=16: send 0xA5 cleanly, then pulse RxAck 5 cycles after RxReady rises. Expect RxData=0xA5, RxReady rising exactly HALF_BIT+9*16+1 cycles after rxs falls, FrameError=0, RxReady=0 the cycle after RxAck.
- Send 0x00 then 0xFF back-to-back with no idle bits and no RxAck. Expect RxData=0xFF and Overrun=1 after the second frame; one RxAck clears both flags.
- Drive a 3-cycle low glitch on an idle line. Expect a return to RX_IDLE at the start mid-sample, RxReady=0, no flag changes, and a following 0x3C received correctly.
- Send 0x55 with the stop bit forced low, then hold the line low for 40 bit times. Expect FrameError=1, RxReady=0, RxData unchanged, Busy=1 until the line returns high, then correct reception of 0x81.
- Assert RxAck exactly on the cycle RxReady would rise for a second byte 0x12. Expect RxReady=1, RxData=0x12, Overrun=0.
- Assert Reset during data bit 4 of a frame. Expect all outputs at 0 and state RX_IDLE next cycle, and the remainder of the aborted frame not producing RxReady. A clean frame following the line idling for 10 bits is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - UART receiver serial line and consumer handshake bundle
interface uart_rx_if;
    logic       RxD;
    logic       RxAck;
    logic [7:0] RxData;
    logic       RxReady;
    logic       FrameError;
    logic       Overrun;
    logic       Busy;

    modport master (
        input  RxD, RxAck,
        output RxData, RxReady, FrameError, Overrun, Busy
    );

    modport slave (
        output RxD, RxAck,
        input  RxData, RxReady, FrameError, Overrun, Busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with sticky ready/overrun/framing flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic      Clock,
    input  logic      Reset,
    uart_rx_if.master rx
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    rx_state_t state, state_next;

    logic          rx_meta, rxs;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    rx_data, rx_data_next;
    logic          rx_ready, rx_ready_next;
    logic          frame_error, frame_error_next;
    logic          overrun, overrun_next;
    logic          half_tick, bit_tick, byte_done, stop_bad;

    assign half_tick = (baud_cnt == HALF_LAST);
    assign bit_tick  = (baud_cnt == BIT_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx.RxD;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= RX_IDLE;
        else       state <= state_next;
    end

    // RX_BREAK holds off start detection until the line has returned high
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (!rxs)                        state_next = RX_START;
            RX_START: if (half_tick)                   state_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (bit_tick)                    state_next = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rxs)                         state_next = RX_IDLE;
            default:                                   state_next = RX_IDLE;
        endcase
    end

    // A completing byte wins over a same-cycle acknowledge
    always_comb begin
        byte_done        = (state == RX_STOP) && bit_tick && rxs;
        stop_bad         = (state == RX_STOP) && bit_tick && !rxs;
        rx_data_next     = byte_done ? shift_reg : rx_data;
        rx_ready_next    = byte_done | (rx_ready & ~rx.RxAck);
        overrun_next     = ~rx.RxAck & (overrun | (byte_done & rx_ready));
        frame_error_next = stop_bad | (frame_error & ~rx.RxAck);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_ready    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Terminal-count wrap keeps the bit period exact for non-power-of-two rates
            if (state_next != state || bit_tick) baud_cnt <= '0;
            else                                 baud_cnt <= baud_cnt + CW'(1);
            if (state == RX_START) begin
                bit_idx <= '0;
            end else if (state == RX_DATA && bit_tick) begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {rxs, shift_reg[7:1]};
            end
            rx_data     <= rx_data_next;
            rx_ready    <= rx_ready_next;
            frame_error <= frame_error_next;
            overrun     <= overrun_next;
        end
    end

    assign rx.RxData     = rx_data;
    assign rx.RxReady    = rx_ready;
    assign rx.FrameError = frame_error;
    assign rx.Overrun    = overrun;
    assign rx.Busy       = (state != RX_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - Self-checking bench for uart_rx: vector table, corner sequences, random frames
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // Ticks from driving the start bit until RxReady is visible (2 sync stages + register)
    localparam int LAT  = HALF + 9 * CPB + 3;

    logic Clock = 1'b0;
    logic Reset;
    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (.Clock(Clock), .Reset(Reset), .rx(bus));

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_data;
    logic       m_ready, m_fe, m_ovr;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack;
        logic [7:0] e_data;
        logic       e_ready;
        logic       e_fe;
        logic       e_ovr;
    } vec_t;
    vec_t tbl [6];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_byte({tag, " data"},  bus.RxData,     m_data);
        check_bit ({tag, " ready"}, bus.RxReady,    m_ready);
        check_bit ({tag, " fe"},    bus.FrameError, m_fe);
        check_bit ({tag, " ovr"},   bus.Overrun,    m_ovr);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.RxD = bits[i];
            ticks(CPB);
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            m_ovr   = m_ovr | m_ready;
            m_ready = 1'b1;
            m_data  = d;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic model_ack();
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.RxAck = 1'b1;
        tick();
        bus.RxAck = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       rstop, rack;
        int         rgap;

        tbl[0] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h5A, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'hE7, 1'b1, 1'b1, 8'hE7, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b0, 1'b1, 8'hE7, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'hC9, 1'b1, 1'b0, 8'hC9, 1'b1, 1'b0, 1'b0};

        Reset     = 1'b1;
        bus.RxD   = 1'b1;
        bus.RxAck = 1'b0;
        ticks(3);
        Reset = 1'b0;
        tick();
        check_byte("reset data", bus.RxData, 8'h00);
        check_bit ("reset ready", bus.RxReady, 1'b0);
        check_bit ("reset fe", bus.FrameError, 1'b0);
        check_bit ("reset ovr", bus.Overrun, 1'b0);
        check_bit ("reset busy", bus.Busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].stop);
            check_byte($sformatf("tbl%0d data", i),  bus.RxData,     tbl[i].e_data);
            check_bit ($sformatf("tbl%0d ready", i), bus.RxReady,    tbl[i].e_ready);
            check_bit ($sformatf("tbl%0d fe", i),    bus.FrameError, tbl[i].e_fe);
            check_bit ($sformatf("tbl%0d ovr", i),   bus.Overrun,    tbl[i].e_ovr);
            if (tbl[i].ack) begin
                pulse_ack();
                check_bit ($sformatf("tbl%0d ack ready", i), bus.RxReady,    1'b0);
                check_bit ($sformatf("tbl%0d ack fe", i),    bus.FrameError, 1'b0);
                check_bit ($sformatf("tbl%0d ack ovr", i),   bus.Overrun,    1'b0);
            end
            bus.RxD = 1'b1;
            ticks(CPB);
        end
        m_data = 8'hC9;
        pulse_ack();
        model_ack();

        // Clean 0xA5 with exact ready latency, acked five cycles after it rises
        fork
            send_frame(8'hA5, 1'b1);
            begin
                ticks(LAT - 1);
                check_bit("a5 ready early", bus.RxReady, 1'b0);
                check_bit("a5 busy", bus.Busy, 1'b1);
                tick();
                check_bit("a5 ready rise", bus.RxReady, 1'b1);
                check_byte("a5 data", bus.RxData, 8'hA5);
                check_bit("a5 fe", bus.FrameError, 1'b0);
                ticks(4);
                pulse_ack();
                check_bit("a5 ready after ack", bus.RxReady, 1'b0);
            end
        join
        m_data = 8'hA5;
        ticks(CPB);

        send_frame(8'h00, 1'b1);
        model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        model_frame(8'hFF, 1'b1);
        check_model("b2b");
        pulse_ack();
        model_ack();
        check_model("b2b ack");

        // Three-cycle low glitch on an idle line
        ticks(CPB);
        bus.RxD = 1'b0;
        ticks(3);
        bus.RxD = 1'b1;
        ticks(3);
        check_bit("glitch busy", bus.Busy, 1'b1);
        ticks(6);
        check_bit("glitch idle", bus.Busy, 1'b0);
        check_model("glitch");
        ticks(CPB);
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        check_model("after glitch");
        pulse_ack();
        model_ack();

        // Bad stop bit followed by a 40-bit break
        send_frame(8'h55, 1'b0);
        model_frame(8'h55, 1'b0);
        ticks(20 * CPB);
        check_model("break mid");
        check_bit("break busy mid", bus.Busy, 1'b1);
        ticks(20 * CPB);
        check_bit("break busy end", bus.Busy, 1'b1);
        bus.RxD = 1'b1;
        ticks(4);
        check_bit("break released", bus.Busy, 1'b0);
        ticks(CPB);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        check_model("after break");
        pulse_ack();
        model_ack();
        check_model("after break ack");

        // Acknowledge lands on the very cycle the second byte completes
        send_frame(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1);
        fork
            send_frame(8'h12, 1'b1);
            begin
                ticks(LAT - 1);
                bus.RxAck = 1'b1;
                tick();
                bus.RxAck = 1'b0;
                check_bit("ackrace ready", bus.RxReady, 1'b1);
                check_byte("ackrace data", bus.RxData, 8'h12);
                check_bit("ackrace ovr", bus.Overrun, 1'b0);
                check_bit("ackrace fe", bus.FrameError, 1'b0);
            end
        join
        m_data = 8'h12;
        m_ready = 1'b1;
        m_ovr = 1'b0;
        m_fe = 1'b0;

        // Reset during data bit 4; the tail bits are all ones and must produce nothing
        fork
            send_frame(8'hF0, 1'b1);
            begin
                ticks(88);
                Reset = 1'b1;
                tick();
                Reset = 1'b0;
                check_byte("midreset data", bus.RxData, 8'h00);
                check_bit("midreset ready", bus.RxReady, 1'b0);
                check_bit("midreset fe", bus.FrameError, 1'b0);
                check_bit("midreset ovr", bus.Overrun, 1'b0);
                check_bit("midreset busy", bus.Busy, 1'b0);
            end
        join
        m_data = 8'h00;
        model_ack();
        ticks(10 * CPB);
        check_model("midreset tail");
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        check_model("after reset");
        pulse_ack();
        model_ack();

        for (int k = 0; k < 12; k++) begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rack  = 1'($urandom_range(0, 1));
            rgap  = rstop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(rd, rstop);
            model_frame(rd, rstop);
            check_model($sformatf("rnd%0d", k));
            if (rack) begin
                pulse_ack();
                model_ack();
                check_model($sformatf("rnd%0d ack", k));
            end
            bus.RxD = 1'b1;
            ticks(rgap * CPB);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
